// File: rtl/vga_pixel_fifo.sv
// vga_pixel_fifo: bus-writable pixel FIFO that feeds the VGA sync stage.
// Software pushes pixels through a four-register device window. The sync stage
// pulls one pixel per active-video tick. Underruns produce black and are counted.
module vga_pixel_fifo #(
  parameter int CD        = 12,
  parameter int Depth     = 16,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 device_req_i,
  input  logic [AddrWidth-1:0] device_addr_i,
  input  logic                 device_we_i,
  input  logic [3:0]           device_be_i,
  input  logic [DataWidth-1:0] device_wdata_i,
  output logic                 device_rvalid_o,
  output logic [DataWidth-1:0] device_rdata_o,
  input  logic                 pix_req_i,
  output logic [CD-1:0]        pix_rgb_o,
  output logic                 underflow_o
);

  localparam int PW = $clog2(Depth);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] DepthLevel = LW'(Depth);

  logic [CD-1:0] mem [Depth];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          en;
  logic          ovf;
  logic          unf;
  logic [15:0]   underruns;

  logic [1:0]    reg_sel;
  logic          wr_access;
  logic          rd_access;
  logic          data_wr;
  logic          status_wr;
  logic          ctrl_wr;
  logic          count_wr;
  logic          full;
  logic          empty;
  logic          pop;
  logic          unf_evt;
  logic          push;
  logic          ovf_evt;
  logic          flush;
  logic [31:0]   rd_word;
  logic          unused_bits;

  // Byte enables, undecoded address bits and unused data bits are don't-cares.
  assign unused_bits = ^{device_be_i, device_addr_i, device_wdata_i};

  assign reg_sel   = device_addr_i[3:2];
  assign wr_access = device_req_i & device_we_i;
  assign rd_access = device_req_i & ~device_we_i;
  assign data_wr   = wr_access & (reg_sel == 2'd0);
  assign status_wr = wr_access & (reg_sel == 2'd1);
  assign ctrl_wr   = wr_access & (reg_sel == 2'd2);
  assign count_wr  = wr_access & (reg_sel == 2'd3);

  assign full    = (level == DepthLevel);
  assign empty   = (level == '0);
  assign pop     = en & pix_req_i & ~empty;
  assign unf_evt = en & pix_req_i & empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push    = data_wr & (~full | pop);
  assign ovf_evt = data_wr & full & ~pop;
  assign flush   = ctrl_wr & device_wdata_i[1];

  assign underflow_o = unf;

  // Pixel storage; no reset so it maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= device_wdata_i[CD-1:0];
    end
  end

  // Pointers and occupancy; flush wins over the pop it may coincide with.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      level  <= level + LW'(push) - LW'(pop);
    end
  end

  // Pixel output register: head on a served pull, black otherwise, held between pulls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pix_rgb_o <= '0;
    end else if (pix_req_i) begin
      pix_rgb_o <= pop ? mem[rd_ptr] : '0;
    end
  end

  // Control and sticky flags; a new event beats a same-cycle software clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en  <= 1'b0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        en <= device_wdata_i[0];
      end
      ovf <= ovf_evt | (ovf & ~(status_wr & device_wdata_i[18]));
      unf <= unf_evt | (unf & ~(status_wr & device_wdata_i[19]));
    end
  end

  // Saturating underrun counter; an increment during a clear leaves it at 1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      underruns <= '0;
    end else if (unf_evt) begin
      if (count_wr) begin
        underruns <= 16'd1;
      end else if (underruns != 16'hFFFF) begin
        underruns <= underruns + 16'd1;
      end
    end else if (count_wr) begin
      underruns <= '0;
    end
  end

  // Register read mux, evaluated on the request cycle's pre-edge state.
  always_comb begin
    rd_word = '0;
    case (reg_sel)
      2'd1: begin
        rd_word[LW-1:0] = level;
        rd_word[16]     = full;
        rd_word[17]     = empty;
        rd_word[18]     = ovf;
        rd_word[19]     = unf;
      end
      2'd2:    rd_word[0] = en;
      2'd3:    rd_word[15:0] = underruns;
      default: rd_word = '0;
    endcase
  end

  // Single-cycle bus response; writes return zero data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      device_rvalid_o <= 1'b0;
      device_rdata_o  <= '0;
    end else begin
      device_rvalid_o <= device_req_i;
      device_rdata_o  <= rd_access ? DataWidth'(rd_word) : '0;
    end
  end

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// tb_vga_pixel_fifo: directed stimulus against a queue-based model of the
// pixel FIFO, with an every-cycle compare and hand-computed literal checks.
module tb_vga_pixel_fifo;

  localparam int CD    = 12;
  localparam int Depth = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'hF;
  logic [31:0] wdata = '0;
  logic        rvalid;
  logic [31:0] rdata;
  logic        pix_req = 1'b0;
  logic [CD-1:0] pix_rgb;
  logic        underflow;

  int passes = 0;
  int total  = 0;

  // Reference model state
  int          q[$];
  bit          m_en, m_ovf, m_unf;
  int          m_unr;
  logic [31:0] m_pix;
  bit          m_rvalid;
  logic [31:0] m_rdata;

  always #5 clk = ~clk;

  vga_pixel_fifo #(.CD(CD), .Depth(Depth), .AddrWidth(32), .DataWidth(32)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .device_req_i   (req),
    .device_addr_i  (addr),
    .device_we_i    (we),
    .device_be_i    (be),
    .device_wdata_i (wdata),
    .device_rvalid_o(rvalid),
    .device_rdata_o (rdata),
    .pix_req_i      (pix_req),
    .pix_rgb_o      (pix_rgb),
    .underflow_o    (underflow)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
  endtask

  function automatic logic [31:0] modelRead(input logic [1:0] r);
    logic [31:0] v;
    v = '0;
    case (r)
      2'd1: begin
        v = 32'(q.size());
        v[16] = (q.size() == Depth);
        v[17] = (q.size() == 0);
        v[18] = m_ovf;
        v[19] = m_unf;
      end
      2'd2: v[0] = m_en;
      2'd3: v = 32'(m_unr);
      default: v = '0;
    endcase
    return v;
  endfunction

  // Model update on each clock edge from the inputs held across that edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_en = 0; m_ovf = 0; m_unf = 0; m_unr = 0;
      m_pix = '0; m_rvalid = 0; m_rdata = '0;
    end else begin
      m_rvalid = req;
      m_rdata  = (req && !we) ? modelRead(addr[3:2]) : '0;
      if (req && we && addr[3:2] == 2'd1) begin
        if (wdata[18]) m_ovf = 0;
        if (wdata[19]) m_unf = 0;
      end
      if (req && we && addr[3:2] == 2'd3) m_unr = 0;
      if (pix_req) begin
        if (!m_en) m_pix = '0;
        else if (q.size() > 0) m_pix = 32'(q.pop_front());
        else begin
          m_pix = '0;
          m_unf = 1;
          if (m_unr < 65535) m_unr++;
        end
      end
      if (req && we && addr[3:2] == 2'd0) begin
        if (q.size() < Depth) q.push_back(int'(wdata[CD-1:0]));
        else m_ovf = 1;
      end
      if (req && we && addr[3:2] == 2'd2) begin
        m_en = wdata[0];
        if (wdata[1]) q.delete();
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("pix_rgb", 32'(pix_rgb), m_pix);
      checkOutput("underflow", 32'(underflow), 32'(m_unf));
      checkOutput("rvalid", 32'(rvalid), 32'(m_rvalid));
      checkOutput("rdata", rdata, m_rdata);
    end
  end

  task automatic applyStimulus(input bit r_req, input bit r_we, input logic [1:0] r_sel,
                               input logic [31:0] r_wdata, input bit r_pix);
    req     = r_req;
    we      = r_we;
    addr    = {28'd0, r_sel, 2'b00};
    wdata   = r_wdata;
    pix_req = r_pix;
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0; wdata = '0; pix_req = 1'b0;
  endtask

  task automatic writeReg(input logic [1:0] r_sel, input logic [31:0] v);
    applyStimulus(1, 1, r_sel, v, 0);
  endtask

  task automatic readReg(input logic [1:0] r_sel, output logic [31:0] v);
    applyStimulus(1, 0, r_sel, '0, 0);
    v = rdata;
  endtask

  task automatic pull();
    applyStimulus(0, 0, 2'd0, '0, 1);
  endtask

  logic [31:0] rd;

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_pix", 32'(pix_rgb), 32'h0);
    checkOutput("reset_rvalid", 32'(rvalid), 32'h0);
    checkOutput("reset_underflow", 32'(underflow), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    readReg(2'd1, rd);
    checkOutput("reset_status", rd, 32'h0002_0000);

    // Basic push then pull in order
    writeReg(2'd2, 32'h1);
    writeReg(2'd0, 32'h123);
    writeReg(2'd0, 32'h456);
    writeReg(2'd0, 32'hABC);
    readReg(2'd1, rd);
    checkOutput("status_level3", rd, 32'h0000_0003);
    pull(); checkOutput("pix_1", 32'(pix_rgb), 32'h123);
    pull(); checkOutput("pix_2", 32'(pix_rgb), 32'h456);
    pull(); checkOutput("pix_3", 32'(pix_rgb), 32'hABC);
    readReg(2'd1, rd);
    checkOutput("status_drained", rd, 32'h0002_0000);

    // Overfill: 17th push dropped and flagged
    for (int i = 0; i < 17; i++) writeReg(2'd0, 32'h100 + 32'(i));
    readReg(2'd1, rd);
    checkOutput("status_full_ovf", rd, 32'h0005_0010);
    for (int i = 0; i < 16; i++) begin
      pull();
      checkOutput("pix_fill", 32'(pix_rgb), 32'h100 + 32'(i));
    end
    readReg(2'd1, rd);
    checkOutput("status_empty_ovf", rd, 32'h0006_0000);

    // Underruns while enabled and empty
    for (int i = 0; i < 3; i++) begin
      pull();
      checkOutput("pix_underrun", 32'(pix_rgb), 32'h0);
    end
    checkOutput("underflow_set", 32'(underflow), 32'h1);
    readReg(2'd3, rd);
    checkOutput("underruns_3", rd, 32'h3);
    readReg(2'd1, rd);
    checkOutput("status_ovf_unf", rd, 32'h000E_0000);
    writeReg(2'd1, 32'h0008_0000);
    checkOutput("underflow_cleared", 32'(underflow), 32'h0);
    readReg(2'd1, rd);
    checkOutput("status_unf_cleared", rd, 32'h0006_0000);
    writeReg(2'd1, 32'h0004_0000);
    readReg(2'd1, rd);
    checkOutput("status_ovf_cleared", rd, 32'h0002_0000);

    // Push and pull together while empty: underflow, no bypass
    applyStimulus(1, 1, 2'd0, 32'h055, 1);
    checkOutput("pix_empty_pushpop", 32'(pix_rgb), 32'h0);
    readReg(2'd1, rd);
    checkOutput("status_empty_pushpop", rd, 32'h0008_0001);
    writeReg(2'd1, 32'h0008_0000);
    writeReg(2'd2, 32'h3);

    // Push and pull together while full
    for (int i = 0; i < 16; i++) writeReg(2'd0, 32'h200 + 32'(i));
    readReg(2'd1, rd);
    checkOutput("status_full", rd, 32'h0001_0010);
    applyStimulus(1, 1, 2'd0, 32'h2FF, 1);
    checkOutput("pix_full_pushpop", 32'(pix_rgb), 32'h200);
    readReg(2'd1, rd);
    checkOutput("status_full_pushpop", rd, 32'h0001_0010);

    // Flush coinciding with a pull serves the old head
    applyStimulus(1, 1, 2'd2, 32'h3, 1);
    checkOutput("pix_flush_pop", 32'(pix_rgb), 32'h201);
    readReg(2'd1, rd);
    checkOutput("status_flushed", rd, 32'h0002_0000);
    readReg(2'd2, rd);
    checkOutput("ctrl_after_flush", rd, 32'h1);

    // Disabled: pulls give black and touch nothing
    writeReg(2'd2, 32'h0);
    writeReg(2'd0, 32'h777);
    pull();
    checkOutput("pix_disabled", 32'(pix_rgb), 32'h0);
    readReg(2'd1, rd);
    checkOutput("status_disabled", rd, 32'h0000_0001);
    readReg(2'd3, rd);
    checkOutput("underruns_disabled", rd, 32'h4);

    // Saturation of the underrun counter
    writeReg(2'd2, 32'h3);
    writeReg(2'd3, 32'h0);
    for (int i = 0; i < 65540; i++) pull();
    readReg(2'd3, rd);
    checkOutput("underruns_sat", rd, 32'h0000_FFFF);

    // Set beats same-cycle clear
    applyStimulus(1, 1, 2'd1, 32'h0008_0000, 1);
    checkOutput("unf_set_wins", 32'(underflow), 32'h1);
    applyStimulus(1, 1, 2'd3, 32'h0, 1);
    readReg(2'd3, rd);
    checkOutput("underruns_set_wins", rd, 32'h1);

    // Reset mid-operation drops an outstanding response
    writeReg(2'd0, 32'h3C3);
    pull();
    checkOutput("pix_before_reset", 32'(pix_rgb), 32'h3C3);
    writeReg(2'd0, 32'h111);
    applyStimulus(1, 0, 2'd1, '0, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_rvalid", 32'(rvalid), 32'h0);
    checkOutput("midreset_pix", 32'(pix_rgb), 32'h0);
    checkOutput("midreset_underflow", 32'(underflow), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    readReg(2'd1, rd);
    checkOutput("status_after_reset", rd, 32'h0002_0000);
    readReg(2'd2, rd);
    checkOutput("ctrl_after_reset", rd, 32'h0);
    readReg(2'd3, rd);
    checkOutput("underruns_after_reset", rd, 32'h0);

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
